reg_transfer_sequencer: RTL and testbench
=========================================

// Module: reg_transfer_sequencer
// PURPOSE
//  Multi-cycle micro-op sequencer for the CPU register file and shared 16-bit bus.
//  Accepts one register-level op (MOV/LOAD/STORE/PUSH/POP) and drives the register
//  select codes, MAR/memory strobes, SP adjust and segment select, one bus phase
//  per cycle. Guarantees a single bus driver per cycle; sits between decode and RegistersUnit.
// PARAMETERS
//  TIMEOUT  15  max cycles waiting for mem_ready in RD/WR before abort (1..255)
//  RC_W     4   width of register select codes
// PORTS
//  clk        in   1     clock; all state changes on rising edge
//  r          in   1     reset, synchronous, active-low
//  start      in   1     op request; accepted only when busy=0
//  op         in   3     0 NOP,1 MOV,2 LOAD,3 STORE,4 PUSH,5 POP; 6-7 illegal
//  src        in   RC_W  source reg code (1 A..5 E,6 SP,7 SB,8 CS,9 DS,10 SS,11 ES)
//  dst        in   RC_W  destination reg code (same encoding)
//  mem_ready  in   1     memory completes RD/WR this cycle
//  busy       out  1     state != IDLE
//  done       out  1     one-cycle pulse on op completion (also on abort)
//  err        out  1     one-cycle pulse with done on illegal op/code or timeout
//  rso        out  RC_W  register output-enable code to bus (0 = none)
//  rsi        out  RC_W  register write-enable code from bus (0 = none)
//  sso        out  3     segment select: 2 DS for LOAD/STORE, 3 SS for PUSH/POP, else 0
//  mar_we     out  1     load memory address register from bus
//  mem_rd     out  1     memory read strobe, held until mem_ready
//  mem_wr     out  1     memory write strobe, held until mem_ready
//  mem_oe     out  1     memory data drives bus
//  sp_inc     out  1     SP += 1 pulse
//  sp_dec     out  1     SP -= 1 pulse
// BEHAVIOUR
//  - Reset (r=0 at edge): state IDLE, latched op/src/dst=0, timer=0; all outputs 0 next cycle.
//    Reset mid-op aborts: no done, no err, no further strobes.
//  - Accept: start=1 & IDLE at edge T latches op/src/dst; first phase at T+1.
//    start while busy is ignored (not queued).
//  - Validation at accept: codes 0 or 12-15 in a used field, or op 6/7 -> ERR phase
//    (done=err=1 at T+1, no bus activity). NOP -> done at T+1, err=0.
//  - Phases (one state each):
//    MOV:   XFER(rso=src,rsi=dst) -> DONE
//    LOAD:  ADDR(rso=src,mar_we) -> RD(mem_rd) -> WB(mem_oe,rsi=dst) -> DONE
//    STORE: ADDR(rso=dst,mar_we) -> WR(rso=src,mem_wr) -> DONE
//    PUSH:  SPDEC(sp_dec) -> ADDR(rso=6,mar_we) -> WR(rso=src,mem_wr) -> DONE
//    POP:   ADDR(rso=6,mar_we) -> RD(mem_rd) -> WB(mem_oe,rsi=dst) -> SPINC(sp_inc) -> DONE
//  - sso held constant for whole op (DS/SS as above) from first phase to DONE inclusive.
//  - RD/WR: stay while mem_ready=0; leave at edge where mem_ready=1. Zero-wait memory
//    => RD/WR lasts exactly 1 cycle. mem_ready outside RD/WR ignored.
//  - Timeout: timer clears on entering RD/WR, increments each waiting cycle; reaching
//    TIMEOUT without mem_ready -> ERR (done=err=1); POP then skips WB and SPINC.
//  - DONE: done=1 for one cycle, then IDLE; busy deasserts the cycle after done.
//    New start may be sampled in the DONE cycle? No: only in IDLE.
//  - Latency, zero-wait: MOV 2, STORE 3, LOAD 4, PUSH 4, POP 5 cycles start->done.
//  - Invariants: at most one of (rso!=0, mem_oe) per cycle; mem_rd&mem_wr never both;
//    sp_inc&sp_dec never both; rsi!=0 only in XFER/WB.
//  - src==dst MOV is legal (reg rewrites own value). PUSH src=6 pushes pre-decrement?
//    No: SP is decremented first, so the decremented SP value is stored.
// STRUCTURE
//  - cpu_seq_pkg: reg code localparams (REG_NONE..REG_ES), op enum, state enum,
//    SEG_DS/SEG_SS constants; shared with decode.
//  - Sub-module mem_wait_timer (clear, en -> expired) for the TIMEOUT counter.
//  - Outputs registered from state (Moore); no combinational path from start to strobes.
// TESTING
//  1 MOV src=1 dst=4, start at T -> T+1 rso=1 rsi=4; T+2 done=1; busy low at T+3.
//  2 LOAD src=9 dst=2, mem_ready 2 cycles late -> ADDR(rso=9,mar_we,sso=2), mem_rd 3 cycles,
//    WB(mem_oe,rsi=2), done at T+6; bus never double-driven.
//  3 PUSH src=3 then POP dst=5, zero-wait -> sp_dec before mar_we(rso=6); POP sp_inc after
//    rsi=5; sso=3 throughout; done at T+4 and T+5 respectively.
//  4 STORE with mem_ready held 0 -> exactly TIMEOUT wait cycles, then done=err=1, IDLE.
//  5 Illegal: MOV dst=0, op=7, src=13 -> done=err=1 at T+1, rso=rsi=0 and no strobes.
//  6 r=0 during POP RD, start held high while busy -> all outputs 0 next cycle, no done,
//    no sp_inc; starts while busy never accepted.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the register-transfer sequencer and the decode stage:
// register select codes, op and state encodings, segment select values.
package cpu_seq_pkg;

   localparam int REG_NONE = 0;
   localparam int REG_A    = 1;
   localparam int REG_B    = 2;
   localparam int REG_C    = 3;
   localparam int REG_D    = 4;
   localparam int REG_E    = 5;
   localparam int REG_SP   = 6;
   localparam int REG_SB   = 7;
   localparam int REG_CS   = 8;
   localparam int REG_DS   = 9;
   localparam int REG_SS   = 10;
   localparam int REG_ES   = 11;

   localparam logic [2:0] SEG_NONE = 3'd0;
   localparam logic [2:0] SEG_DS   = 3'd2;
   localparam logic [2:0] SEG_SS   = 3'd3;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MOV   = 3'd1,
      OP_LOAD  = 3'd2,
      OP_STORE = 3'd3,
      OP_PUSH  = 3'd4,
      OP_POP   = 3'd5
   } op_t;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_XFER  = 4'd1,
      ST_ADDR  = 4'd2,
      ST_RD    = 4'd3,
      ST_WR    = 4'd4,
      ST_WB    = 4'd5,
      ST_SPDEC = 4'd6,
      ST_SPINC = 4'd7,
      ST_DONE  = 4'd8,
      ST_ERR   = 4'd9
   } state_t;

   function automatic logic code_ok(input int c);
      return (c >= REG_A) && (c <= REG_ES);
   endfunction

   function automatic logic [2:0] op_seg(input logic [2:0] o);
      case (o)
         OP_LOAD, OP_STORE: return SEG_DS;
         OP_PUSH, OP_POP:   return SEG_SS;
         default:           return SEG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the last allowed
// waiting cycle so the sequencer can abort on that edge.
module mem_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic r,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (!r || clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Multi-cycle micro-op sequencer: one bus phase per cycle for MOV/LOAD/STORE/PUSH/POP.
// Outputs are decoded from the registered state only, so start never reaches a strobe.
module reg_transfer_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int RC_W    = 4
) (
   input  logic            clk,
   input  logic            r,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [RC_W-1:0] src,
   input  logic [RC_W-1:0] dst,
   input  logic            mem_ready,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [RC_W-1:0] rso,
   output logic [RC_W-1:0] rsi,
   output logic [2:0]      sso,
   output logic            mar_we,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic            mem_oe,
   output logic            sp_inc,
   output logic            sp_dec,
   output state_t          dbg_state
);

   state_t          state, state_nx;
   logic [2:0]      op_q;
   logic [RC_W-1:0] src_q, dst_q;
   logic            accept, req_ok, waiting, tmr_expired;

   assign accept  = start && (state == ST_IDLE);
   assign waiting = (state == ST_RD) || (state == ST_WR);

   // Only the register fields an op actually uses are validated.
   always_comb begin
      req_ok = 1'b0;
      case (op)
         OP_NOP:                     req_ok = 1'b1;
         OP_MOV, OP_LOAD, OP_STORE:  req_ok = code_ok(int'(src)) && code_ok(int'(dst));
         OP_PUSH:                    req_ok = code_ok(int'(src));
         OP_POP:                     req_ok = code_ok(int'(dst));
         default:                    req_ok = 1'b0;
      endcase
   end

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .r       (r),
      .clear   (!waiting),
      .en      (waiting && !mem_ready),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!r) begin
         state <= ST_IDLE;
         op_q  <= '0;
         src_q <= '0;
         dst_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_q  <= op;
            src_q <= src;
            dst_q <= dst;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!req_ok) begin
                  state_nx = ST_ERR;
               end else begin
                  case (op)
                     OP_NOP:                    state_nx = ST_DONE;
                     OP_MOV:                    state_nx = ST_XFER;
                     OP_LOAD, OP_STORE, OP_POP: state_nx = ST_ADDR;
                     OP_PUSH:                   state_nx = ST_SPDEC;
                     default:                   state_nx = ST_ERR;
                  endcase
               end
            end
         end
         ST_XFER:  state_nx = ST_DONE;
         ST_SPDEC: state_nx = ST_ADDR;
         ST_ADDR:  state_nx = ((op_q == OP_LOAD) || (op_q == OP_POP)) ? ST_RD : ST_WR;
         ST_RD: begin
            if (mem_ready)        state_nx = ST_WB;
            else if (tmr_expired) state_nx = ST_ERR;
         end
         ST_WR: begin
            if (mem_ready)        state_nx = ST_DONE;
            else if (tmr_expired) state_nx = ST_ERR;
         end
         ST_WB:    state_nx = (op_q == OP_POP) ? ST_SPINC : ST_DONE;
         ST_SPINC: state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         ST_ERR:   state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      rso    = '0;
      rsi    = '0;
      mar_we = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      mem_oe = 1'b0;
      sp_inc = 1'b0;
      sp_dec = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      case (state)
         ST_XFER: begin
            rso = src_q;
            rsi = dst_q;
         end
         ST_ADDR: begin
            mar_we = 1'b1;
            case (op_q)
               OP_LOAD:  rso = src_q;
               OP_STORE: rso = dst_q;
               default:  rso = RC_W'(REG_SP);
            endcase
         end
         ST_RD:    mem_rd = 1'b1;
         ST_WR: begin
            rso    = src_q;
            mem_wr = 1'b1;
         end
         ST_WB: begin
            mem_oe = 1'b1;
            rsi    = dst_q;
         end
         ST_SPDEC: sp_dec = 1'b1;
         ST_SPINC: sp_inc = 1'b1;
         ST_DONE:  done = 1'b1;
         ST_ERR: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy      = (state != ST_IDLE);
   assign sso       = (busy && (state != ST_ERR)) ? op_seg(op_q) : SEG_NONE;
   assign dbg_state = state;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Randomized bench: each issued op expands into its expected per-cycle output
// trace, and a monitor compares every cycle against that trace (or idle zeros).
module tb_reg_transfer_sequencer;
   import cpu_seq_pkg::*;

   localparam int TO = 15;
   localparam int W  = 20;

   logic       clk = 1'b0;
   logic       r = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = '0;
   logic [3:0] src = '0, dst = '0;
   logic       mem_ready = 1'b0;
   logic       busy, done, err, mar_we, mem_rd, mem_wr, mem_oe, sp_inc, sp_dec;
   logic [3:0] rso, rsi;
   logic [2:0] sso;
   state_t     dbg_state;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cur_wait = 0;
   int wcnt = 0;
   int cyc = 0;

   reg_transfer_sequencer #(.TIMEOUT(TO), .RC_W(4)) dut (
      .clk(clk), .r(r), .start(start), .op(op), .src(src), .dst(dst),
      .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
      .rso(rso), .rsi(rsi), .sso(sso), .mar_we(mar_we), .mem_rd(mem_rd),
      .mem_wr(mem_wr), .mem_oe(mem_oe), .sp_inc(sp_inc), .sp_dec(sp_dec),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // reference model: word = busy,done,err,rso,rsi,sso,mar_we,rd,wr,oe,inc,dec
   function automatic logic [W-1:0] mk(input logic d, input logic e, input int so,
                                       input int si, input int sg, input logic mar,
                                       input logic rd, input logic wr, input logic oe,
                                       input logic inc, input logic dec);
      logic [3:0] so4, si4;
      logic [2:0] sg3;
      so4 = so[3:0];
      si4 = si[3:0];
      sg3 = sg[2:0];
      return {1'b1, d, e, so4, si4, sg3, mar, rd, wr, oe, inc, dec};
   endfunction

   function automatic bit cv(input int c);
      return (c >= 1) && (c <= 11);
   endfunction

   function automatic void model(input int o, input int s, input int d, input int w);
      bit legal;
      int sg, n;
      bit tmo;
      case (o)
         0:       legal = 1;
         1, 2, 3: legal = cv(s) && cv(d);
         4:       legal = cv(s);
         5:       legal = cv(d);
         default: legal = 0;
      endcase
      sg  = (o == 2 || o == 3) ? 2 : (o == 4 || o == 5) ? 3 : 0;
      tmo = (w >= TO);
      n   = tmo ? TO : w + 1;
      if (!legal) begin
         exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
         return;
      end
      case (o)
         1: exp_q.push_back(mk(0, 0, s, d, sg, 0, 0, 0, 0, 0, 0));
         2: begin
            exp_q.push_back(mk(0, 0, s, 0, sg, 1, 0, 0, 0, 0, 0));
            repeat (n) exp_q.push_back(mk(0, 0, 0, 0, sg, 0, 1, 0, 0, 0, 0));
            if (!tmo) exp_q.push_back(mk(0, 0, 0, d, sg, 0, 0, 0, 1, 0, 0));
         end
         3: begin
            exp_q.push_back(mk(0, 0, d, 0, sg, 1, 0, 0, 0, 0, 0));
            repeat (n) exp_q.push_back(mk(0, 0, s, 0, sg, 0, 0, 1, 0, 0, 0));
         end
         4: begin
            exp_q.push_back(mk(0, 0, 0, 0, sg, 0, 0, 0, 0, 0, 1));
            exp_q.push_back(mk(0, 0, 6, 0, sg, 1, 0, 0, 0, 0, 0));
            repeat (n) exp_q.push_back(mk(0, 0, s, 0, sg, 0, 0, 1, 0, 0, 0));
         end
         5: begin
            exp_q.push_back(mk(0, 0, 6, 0, sg, 1, 0, 0, 0, 0, 0));
            repeat (n) exp_q.push_back(mk(0, 0, 0, 0, sg, 0, 1, 0, 0, 0, 0));
            if (!tmo) begin
               exp_q.push_back(mk(0, 0, 0, d, sg, 0, 0, 0, 1, 0, 0));
               exp_q.push_back(mk(0, 0, 0, 0, sg, 0, 0, 0, 0, 1, 0));
            end
         end
         default: ;
      endcase
      if (tmo && o >= 2 && o <= 5) exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      else exp_q.push_back(mk(1, 0, 0, 0, sg, 0, 0, 0, 0, 0, 0));
   endfunction

   // memory responder: mem_ready after cur_wait waiting cycles, noise otherwise
   initial forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
         mem_ready = (wcnt == cur_wait);
         wcnt++;
      end else begin
         wcnt = 0;
         mem_ready = 1'($urandom_range(0, 1));
      end
   end

   // driver: issue one op, then hold random start/op garbage until it finishes
   task automatic issue(input int o, input int s, input int d, input int w);
      int len;
      @(negedge clk);
      start = 1'b1;
      op = o[2:0];
      src = s[3:0];
      dst = d[3:0];
      cur_wait = w;
      model(o, s, d, w);
      len = exp_q.size();
      repeat (len) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         op = 3'($urandom);
         src = 4'($urandom);
         dst = 4'($urandom);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   // reset in the middle of a POP read while start is held high
   task automatic reset_mid_pop();
      @(negedge clk);
      start = 1'b1; op = 3'd5; src = 4'd0; dst = 4'd5; cur_wait = 50;
      model(5, 0, 5, 50);
      repeat (3) begin
         @(negedge clk);
         start = 1'b1; op = 3'd1; src = 4'd1; dst = 4'd2;
      end
      r = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      r = 1'b1;
      start = 1'b0;
   endtask

   // scoreboard monitor
   initial forever begin
      logic [W-1:0] got, e, mask;
      string nm;
      @(posedge clk);
      #1;
      got = {busy, done, err, rso, rsi, sso, mar_we, mem_rd, mem_wr, mem_oe, sp_inc, sp_dec};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mask = e[17] ? ~(W'(7) << 6) : '1;
         nm = "trace";
      end else begin
         e = '0;
         mask = '1;
         nm = "idle";
      end
      checks++;
      if ((got & mask) !== (e & mask)) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, got & mask, e & mask);
      end
   end

   initial begin
      int o, s, d, w;
      r = 1'b0;
      repeat (3) @(negedge clk);
      r = 1'b1;
      idle(1);
      issue(1, 1, 4, 0);
      issue(2, 9, 2, 2);
      issue(4, 3, 0, 0);
      issue(5, 0, 5, 0);
      issue(3, 1, 2, 1000);
      issue(1, 1, 0, 0);
      issue(7, 1, 1, 0);
      issue(2, 13, 1, 0);
      issue(0, 0, 0, 0);
      issue(1, 3, 3, 0);
      issue(4, 6, 0, 1);
      issue(2, 1, 3, TO - 1);
      issue(5, 0, 2, TO);
      idle(2);
      reset_mid_pop();
      idle(2);
      for (int i = 0; i < 150; i++) begin
         o = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
         s = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 11);
         d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 11);
         w = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 3);
         issue(o, s, d, w);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
